// File: rtl/a2d_spi_intf_pkg.sv
// Shared types and constants for the ADC SPI master: sequencer states,
// command-word padding and transaction sizing.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX1,
    GAP,
    TX2,
    DONE
  } a2d_state_t;

  localparam logic [1:0]  CMD_PAD_HI = 2'b00;
  localparam logic [10:0] CMD_PAD_LO = 11'h000;
  localparam int          XFER_BITS  = 16;
  localparam int          RES_BITS   = 12;

  // Channel-select command: the ADC reads the channel from bits [13:11].
  function automatic logic [XFER_BITS-1:0] make_cmd(input logic [2:0] chnnl);
    return {CMD_PAD_HI, chnnl, CMD_PAD_LO};
  endfunction

endpackage

// File: rtl/a2d_spi_intf_if.sv
// Bundle of the controller request/response signals and the ADC SPI pins.
// master = the SPI master block, slave = controller plus ADC side.
interface a2d_spi_if;

  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport master (
    input  strt_cnv, chnnl, MISO,
    output cnv_cmplt, res, SS_n, SCLK, MOSI
  );

  modport slave (
    output strt_cnv, chnnl, MISO,
    input  cnv_cmplt, res, SS_n, SCLK, MOSI
  );

endinterface

// File: rtl/a2d_spi_intf_xfer16.sv
// One 16-bit SPI transaction: SS_n window, SCLK divider with front/back
// porch, MSB-first TX shift on falling edges, RX capture on rising edges.
module spi_xfer16
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [XFER_BITS-1:0] i_cmd,
  input  logic                 i_miso,
  output logic                 o_ss_n,
  output logic                 o_sclk,
  output logic                 o_mosi,
  output logic                 o_done,
  output logic [RES_BITS-1:0]  o_rx
);

  localparam int             CW        = $clog2(SCLK_DIV);
  localparam int             EW        = $clog2(XFER_BITS + 1);
  localparam logic [CW-1:0]  HALF      = CW'(SCLK_DIV / 2);
  localparam logic [CW-1:0]  RISE_AT   = CW'(SCLK_DIV / 2 - 1);
  localparam logic [CW-1:0]  LAST      = CW'(SCLK_DIV - 1);
  localparam logic [EW-1:0]  ALL_RISES = EW'(XFER_BITS);

  logic                 r_ss_n;
  logic [CW-1:0]        r_cnt;
  logic [XFER_BITS-1:0] r_tx;
  logic [RES_BITS-1:0]  r_rx;
  logic [EW-1:0]        r_rises;

  logic w_active;
  logic w_rise;
  logic w_fall;
  logic w_end;

  // Loading HALF makes the counter MSB high for the D/2-cycle front porch.
  assign w_active = ~r_ss_n;
  assign w_rise   = w_active && (r_cnt == RISE_AT);
  assign w_fall   = w_active && (r_cnt == LAST);
  assign w_end    = w_fall && (r_rises == ALL_RISES);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ss_n  <= 1'b1;
      r_cnt   <= HALF;
      r_tx    <= '0;
      r_rx    <= '0;
      r_rises <= '0;
    end else if (!w_active) begin
      if (i_start) begin
        r_ss_n  <= 1'b0;
        r_cnt   <= HALF;
        r_tx    <= i_cmd;
        r_rises <= '0;
      end
    end else if (w_end) begin
      // The would-be 17th falling edge closes the window with SCLK parked high.
      r_ss_n <= 1'b1;
      r_cnt  <= HALF;
    end else begin
      r_cnt <= r_cnt + CW'(1);
      if (w_rise) begin
        r_rx    <= {r_rx[RES_BITS-2:0], i_miso};
        r_rises <= r_rises + EW'(1);
      end
      if (w_fall && (r_rises != '0)) begin
        r_tx <= {r_tx[XFER_BITS-2:0], 1'b0};
      end
    end
  end

  // Only the low 12 received bits are kept; older bits fall off the end.
  assign o_ss_n = r_ss_n;
  assign o_sclk = r_cnt[CW-1];
  assign o_mosi = r_tx[XFER_BITS-1];
  assign o_done = w_end;
  assign o_rx   = r_rx;

endmodule

// File: rtl/a2d_spi_intf.sv
// ADC conversion sequencer: select-channel transaction, SS_n gap, read
// transaction, then a one-cycle cnv_cmplt with the 12-bit result.
module a2d_spi_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input logic       clk,
  input logic       rst,
  a2d_spi_if.master bus
);

  localparam int            GW       = $clog2(SCLK_DIV) - 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(SCLK_DIV / 2 - 1);

  a2d_state_t r_state;
  a2d_state_t w_next;

  logic [2:0]           r_chnnl;
  logic [RES_BITS-1:0]  r_res;
  logic [GW-1:0]        r_gap_cnt;

  logic                 w_start;
  logic                 w_done;
  logic                 w_cnv_cmplt;
  logic [XFER_BITS-1:0] w_cmd;
  logic [RES_BITS-1:0]  w_rx;
  logic                 w_ss_n;
  logic                 w_sclk;
  logic                 w_mosi;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: default assignment first keeps this block latch-free.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.strt_cnv)            w_next = TX1;
      TX1:     if (w_done)                  w_next = GAP;
      GAP:     if (r_gap_cnt == GAP_LAST)   w_next = TX2;
      TX2:     if (w_done)                  w_next = DONE;
      DONE:                                 w_next = IDLE;
      default:                              w_next = IDLE;
    endcase
  end

  always_comb begin
    w_start     = 1'b0;
    w_cnv_cmplt = 1'b0;
    case (r_state)
      IDLE:    w_start     = bus.strt_cnv;
      GAP:     w_start     = (r_gap_cnt == GAP_LAST);
      DONE:    w_cnv_cmplt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chnnl   <= '0;
      r_res     <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (r_state == IDLE && bus.strt_cnv) r_chnnl <= bus.chnnl;
      if (r_state == GAP) r_gap_cnt <= r_gap_cnt + GW'(1);
      else                r_gap_cnt <= '0;
      if (r_state == TX2 && w_done) r_res <= w_rx;
    end
  end

  // First start launches in the accept cycle, before r_chnnl is loaded.
  assign w_cmd = make_cmd((r_state == IDLE) ? bus.chnnl : r_chnnl);

  spi_xfer16 #(
    .SCLK_DIV (SCLK_DIV)
  ) u_xfer (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_cmd   (w_cmd),
    .i_miso  (bus.MISO),
    .o_ss_n  (w_ss_n),
    .o_sclk  (w_sclk),
    .o_mosi  (w_mosi),
    .o_done  (w_done),
    .o_rx    (w_rx)
  );

  assign bus.SS_n      = w_ss_n;
  assign bus.SCLK      = w_sclk;
  assign bus.MOSI      = w_mosi;
  assign bus.cnv_cmplt = w_cnv_cmplt;
  assign bus.res       = r_res;

endmodule
